// File: rtl/pulse_ack_responder.sv
// Four-phase request/acknowledge responder.
// The remote initiator raises req_in; after synchronization the block emits a
// one-cycle req_pulse to local logic, waits for a done strobe (or a bounded
// timeout), raises ack_out and holds it until the request level drops.
module pulse_ack_responder #(
    parameter int SYNC_STEP   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_in,
    input  logic       done,
    input  logic       clr_err,
    output logic       ack_out,
    output logic       req_pulse,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] txn_cnt
);

    // Last timer value of WAIT_DONE before the timeout fires.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        ACK_HI    = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] timer_reg;
    logic        req_pulse_reg;
    logic        ack_reg;
    logic        busy_reg;
    logic        err_reg;
    logic [7:0]  txn_reg;

    logic [SYNC_STEP-1:0] sync_reg;
    logic                 req_s;

    // Synchronizer chain for the asynchronous request level, one flop per stage.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STEP; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the raw asynchronous input.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[0] <= 1'b0;
                    end else begin
                        sync_reg[0] <= req_in;
                    end
                end
            end else begin : g_next
                // Later stages shift the sample along the chain.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign req_s = sync_reg[SYNC_STEP-1];

    // Handshake FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= 16'd0;
            req_pulse_reg <= 1'b0;
            ack_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            txn_reg       <= 8'd0;
        end else begin
            // The strobe lasts one cycle unless IDLE re-arms it below.
            req_pulse_reg <= 1'b0;

            // Clear first so that a timeout in the same cycle overrides it.
            if (clr_err) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (req_s) begin
                        state_reg     <= WAIT_DONE;
                        req_pulse_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        timer_reg     <= 16'd0;
                    end
                end

                WAIT_DONE: begin
                    // done has priority over a coincident timeout. A dropped
                    // request level is deliberately ignored here; ACK_HI will
                    // then see req_s low and release after a single cycle.
                    if (done) begin
                        state_reg <= ACK_HI;
                        ack_reg   <= 1'b1;
                        txn_reg   <= txn_reg + 8'd1;
                    end else if (timer_reg == TIMER_LAST) begin
                        state_reg <= ACK_HI;
                        ack_reg   <= 1'b1;
                        err_reg   <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end

                ACK_HI: begin
                    if (!req_s) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out     = ack_reg;
    assign req_pulse   = req_pulse_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;
    assign txn_cnt     = txn_reg;

endmodule

// File: tb/tb_pulse_ack_responder.sv
// Directed bench for pulse_ack_responder (SYNC_STEP=2, TIMEOUT_CYC=4).
// Cycle c of a transaction is the interval following the c-th clock edge
// after the request is raised; inputs set in cycle c are sampled at its end.
module tb_pulse_ack_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in;
    logic       done;
    logic       clr_err;
    logic       ack_out;
    logic       req_pulse;
    logic       busy;
    logic       timeout_err;
    logic [7:0] txn_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_txn;

    // Per-cycle record of one transaction
    logic       obs_pulse [0:31];
    logic       obs_ack   [0:31];
    logic       obs_busy  [0:31];
    logic       obs_err   [0:31];
    logic [7:0] obs_txn   [0:31];

    // Back-to-back monitor
    logic mon_en = 1'b0;
    int   pulse_count = 0;
    int   gap_viol = 0;
    logic prev_busy = 1'b0;

    pulse_ack_responder #(
        .SYNC_STEP  (2),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .done       (done),
        .clr_err    (clr_err),
        .ack_out    (ack_out),
        .req_pulse  (req_pulse),
        .busy       (busy),
        .timeout_err(timeout_err),
        .txn_cnt    (txn_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (req_pulse === 1'b1) pulse_count++;
            if (req_pulse === 1'b1 && prev_busy === 1'b1) gap_viol++;
            prev_busy = busy;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction and record outputs at the start of every cycle.
    task automatic run_txn(input int done_cyc, input int done2_cyc, input int drop_cyc,
                           input int clr_from, input int clr_to, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            obs_pulse[c] = req_pulse;
            obs_ack[c]   = ack_out;
            obs_busy[c]  = busy;
            obs_err[c]   = timeout_err;
            obs_txn[c]   = txn_cnt;
            req_in  = (c < drop_cyc);
            done    = (c == done_cyc) || (c == done2_cyc);
            clr_err = (c >= clr_from) && (c <= clr_to);
            tick();
        end
        req_in  = 1'b0;
        done    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_in = 1'b0; done = 1'b0; clr_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({ack_out, req_pulse, busy, timeout_err, txn_cnt} !== 12'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: ack=%b pulse=%b busy=%b err=%b txn=%0d, required all 0",
                         c, ack_out, req_pulse, busy, timeout_err, txn_cnt);
            end
            tick();
        end
        exp_txn = 8'd0;
        $display("txn reset: outputs idle after reset");
    endtask

    task automatic test_nominal;
        run_txn(5, -1, 10, -1, -1, 16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_pulse[c] !== (c == 3) || obs_busy[c] !== (c >= 3 && c <= 12) ||
                obs_ack[c] !== (c >= 6 && c <= 12) || obs_err[c] !== 1'b0 ||
                obs_txn[c] !== ((c >= 6) ? exp_txn + 8'd1 : exp_txn)) begin
                errors++;
                $display("FAIL nominal cycle %0d: pulse=%b busy=%b ack=%b err=%b txn=%0d, required pulse=%b busy=%b ack=%b err=0 txn=%0d",
                         c, obs_pulse[c], obs_busy[c], obs_ack[c], obs_err[c], obs_txn[c],
                         c == 3, c >= 3 && c <= 12, c >= 6 && c <= 12,
                         (c >= 6) ? exp_txn + 8'd1 : exp_txn);
            end
        end
        exp_txn = exp_txn + 8'd1;
        $display("txn nominal: done at cycle 5, txn_cnt now %0d", txn_cnt);
    endtask

    task automatic test_timeout;
        // Plain timeout: ack 4 cycles after req_pulse, flag set, count unchanged
        run_txn(-1, -1, 10, -1, -1, 16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_pulse[c] !== (c == 3) || obs_busy[c] !== (c >= 3 && c <= 12) ||
                obs_ack[c] !== (c >= 7 && c <= 12) || obs_err[c] !== (c >= 7) ||
                obs_txn[c] !== exp_txn) begin
                errors++;
                $display("FAIL timeout cycle %0d: pulse=%b busy=%b ack=%b err=%b txn=%0d, required pulse=%b busy=%b ack=%b err=%b txn=%0d",
                         c, obs_pulse[c], obs_busy[c], obs_ack[c], obs_err[c], obs_txn[c],
                         c == 3, c >= 3 && c <= 12, c >= 7 && c <= 12, c >= 7, exp_txn);
            end
        end
        $display("txn timeout: timeout_err=%b txn_cnt=%0d", timeout_err, txn_cnt);

        // clr_err held through the timeout cycle: clears early, set wins at the end
        run_txn(-1, -1, 10, 0, 6, 16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_err[c] !== (c == 0 || c >= 7) || obs_ack[c] !== (c >= 7 && c <= 12)) begin
                errors++;
                $display("FAIL timeout_clr_overlap cycle %0d: err=%b ack=%b, required err=%b ack=%b",
                         c, obs_err[c], obs_ack[c], c == 0 || c >= 7, c >= 7 && c <= 12);
            end
        end
        $display("txn timeout_clr_overlap: timeout_err=%b", timeout_err);

        // Single clr_err pulse clears the sticky flag one cycle later
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: timeout_err=%b, required 1", timeout_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: timeout_err=%b, required 0", timeout_err);
        end
        $display("txn clr_err: timeout_err=%b", timeout_err);
    endtask

    task automatic test_simultaneous;
        run_txn(6, -1, 10, -1, -1, 16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_ack[c] !== (c >= 7 && c <= 12) || obs_err[c] !== 1'b0 ||
                obs_txn[c] !== ((c >= 7) ? exp_txn + 8'd1 : exp_txn)) begin
                errors++;
                $display("FAIL done_vs_timeout cycle %0d: ack=%b err=%b txn=%0d, required ack=%b err=0 txn=%0d",
                         c, obs_ack[c], obs_err[c], obs_txn[c], c >= 7 && c <= 12,
                         (c >= 7) ? exp_txn + 8'd1 : exp_txn);
            end
        end
        exp_txn = exp_txn + 8'd1;
        $display("txn done_vs_timeout: timeout_err=%b txn_cnt=%0d", timeout_err, txn_cnt);
    endtask

    task automatic test_stray_done;
        // done early in WAIT_DONE, then a stray done while in ACK_HI
        run_txn(4, 8, 10, -1, -1, 16);
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_ack[c] !== (c >= 5 && c <= 12) || obs_busy[c] !== (c >= 3 && c <= 12) ||
                obs_err[c] !== 1'b0 || obs_txn[c] !== ((c >= 5) ? exp_txn + 8'd1 : exp_txn)) begin
                errors++;
                $display("FAIL stray_ack_hi cycle %0d: ack=%b busy=%b err=%b txn=%0d, required ack=%b busy=%b err=0 txn=%0d",
                         c, obs_ack[c], obs_busy[c], obs_err[c], obs_txn[c], c >= 5 && c <= 12,
                         c >= 3 && c <= 12, (c >= 5) ? exp_txn + 8'd1 : exp_txn);
            end
        end
        exp_txn = exp_txn + 8'd1;
        $display("txn stray_ack_hi: txn_cnt=%0d", txn_cnt);

        // Stray done in IDLE
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (txn_cnt !== exp_txn || busy !== 1'b0 || ack_out !== 1'b0 ||
            req_pulse !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: txn=%0d busy=%b ack=%b pulse=%b err=%b, required txn=%0d and others 0",
                     txn_cnt, busy, ack_out, req_pulse, timeout_err, exp_txn);
        end
        $display("txn stray_idle: txn_cnt=%0d", txn_cnt);
    endtask

    task automatic test_protocol_violation;
        // req_in high for cycles 0..2 only; req_s low from cycle 5, done at 5
        run_txn(5, -1, 3, -1, -1, 12);
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (obs_pulse[c] !== (c == 3) || obs_ack[c] !== (c == 6) ||
                obs_busy[c] !== (c >= 3 && c <= 6) ||
                obs_txn[c] !== ((c >= 6) ? exp_txn + 8'd1 : exp_txn)) begin
                errors++;
                $display("FAIL protocol_violation cycle %0d: pulse=%b ack=%b busy=%b txn=%0d, required pulse=%b ack=%b busy=%b txn=%0d",
                         c, obs_pulse[c], obs_ack[c], obs_busy[c], obs_txn[c], c == 3, c == 6,
                         c >= 3 && c <= 6, (c >= 6) ? exp_txn + 8'd1 : exp_txn);
            end
        end
        exp_txn = exp_txn + 8'd1;
        $display("txn protocol_violation: one-cycle ack, txn_cnt=%0d", txn_cnt);
    endtask

    task automatic test_reset_mid;
        int n;
        req_in = 1'b1;
        for (int c = 0; c < 4; c++) tick();   // now in cycle 4, WAIT_DONE
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        tick();                               // cycle 5
        rst = 1'b0;
        checks++;
        if ({ack_out, req_pulse, busy, timeout_err, txn_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ack=%b pulse=%b busy=%b err=%b txn=%0d, required all 0",
                     ack_out, req_pulse, busy, timeout_err, txn_cnt);
        end
        exp_txn = 8'd0;
        for (int c = 6; c <= 9; c++) begin
            tick();
            checks++;
            if (req_pulse !== (c == 8)) begin
                errors++;
                $display("FAIL reset_mid_restart cycle %0d: pulse=%b, required %b", c, req_pulse, c == 8);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (ack_out !== 1'b1 || txn_cnt !== exp_txn + 8'd1) begin
            errors++;
            $display("FAIL reset_mid_finish: ack=%b txn=%0d, required ack=1 txn=%0d",
                     ack_out, txn_cnt, exp_txn + 8'd1);
        end
        exp_txn = exp_txn + 8'd1;
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 10) begin tick(); n++; end
        checks++;
        if (ack_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: ack=%b, required 0 within 10 cycles", ack_out);
        end
        tick();
        $display("txn reset_mid: restart pulse seen, txn_cnt=%0d", txn_cnt);
    endtask

    task automatic test_back_to_back;
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_txn = 8'd0;
        mon_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req_in = 1'b1;
            n = 0;
            while (req_pulse !== 1'b1 && n < 10) begin tick(); n++; end
            checks++;
            if (req_pulse !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pulse txn %0d: req_pulse=%b, required 1 within 10 cycles", i, req_pulse);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            exp_txn = exp_txn + 8'd1;
            checks++;
            if (ack_out !== 1'b1 || txn_cnt !== exp_txn) begin
                errors++;
                $display("FAIL b2b_ack txn %0d: ack=%b txn=%0d, required ack=1 txn=%0d",
                         i, ack_out, txn_cnt, exp_txn);
            end
            req_in = 1'b0;
            n = 0;
            while (ack_out !== 1'b0 && n < 10) begin tick(); n++; end
            checks++;
            if (ack_out !== 1'b0) begin
                errors++;
                $display("FAIL b2b_release txn %0d: ack=%b, required 0 within 10 cycles", i, ack_out);
            end
            if (i == 254) begin
                checks++;
                if (txn_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL b2b_count_255: txn_cnt=%0d, required 255", txn_cnt);
                end
            end
        end
        tick(); tick();
        mon_en = 1'b0;
        checks++;
        if (txn_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap: txn_cnt=%0d, required 0", txn_cnt);
        end
        checks++;
        if (pulse_count != 256) begin
            errors++;
            $display("FAIL b2b_pulse_count: %0d strobes, required 256", pulse_count);
        end
        checks++;
        if (gap_viol != 0) begin
            errors++;
            $display("FAIL b2b_idle_gap: %0d pulses without a preceding idle cycle, required 0", gap_viol);
        end
        $display("txn back_to_back: 256 transactions, txn_cnt=%0d strobes=%0d", txn_cnt, pulse_count);
    endtask

    initial begin
        rst = 1'b1; req_in = 1'b0; done = 1'b0; clr_err = 1'b0;
        exp_txn = 8'd0;
        test_reset();
        test_nominal();
        test_timeout();
        test_simultaneous();
        test_stray_done();
        test_protocol_violation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_ack_responder.md
PULSE_ACK_RESPONDER -- requirements
Module: pulse_ack_responder

Interface
REQ-001 The module SHALL have parameter SYNC_STEP, default 2, giving the number of synchronizer flops on req_in (legal range 2..4).
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum number of cycles spent in WAIT_DONE (legal range 1..65535).
REQ-003 Port clk, input, 1 bit: the single clock for all logic in the block.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req_in, input, 1 bit: four-phase request level from the remote initiator, asynchronous to clk.
REQ-006 Port done, input, 1 bit: single-cycle completion strobe from local logic.
REQ-007 Port clr_err, input, 1 bit: clears timeout_err.
REQ-008 Port ack_out, output, 1 bit: four-phase acknowledge level returned to the initiator.
REQ-009 Port req_pulse, output, 1 bit: single-cycle request strobe to local logic.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port timeout_err, output, 1 bit: sticky timeout flag.
REQ-012 Port txn_cnt, output, 8 bits: count of transactions completed by done.

Function
REQ-013 req_in SHALL pass through a SYNC_STEP-deep flop chain (reset value 0) to produce req_s, and only req_s SHALL be used by the FSM.
REQ-014 The FSM SHALL have three states (IDLE, WAIT_DONE, ACK_HI) and reset to IDLE.
REQ-015 IDLE with req_s==1 SHALL go to WAIT_DONE and set req_pulse=1 for exactly that next cycle, clearing it after one cycle.
REQ-016 Latency from a req_in rising edge meeting setup to the req_pulse high cycle SHALL be SYNC_STEP+1 clk cycles.
REQ-017 In WAIT_DONE, a 16-bit timer SHALL start at 0 on entry and increment each cycle; done is sampled in every WAIT_DONE cycle, including the req_pulse cycle.
REQ-018 WAIT_DONE with done==1 SHALL go to ACK_HI, set ack_out=1 on the next cycle, and increment txn_cnt by 1 (wrapping 255 to 0).
REQ-019 WAIT_DONE with the timer==TIMEOUT_CYC-1 and done==0 SHALL go to ACK_HI, set ack_out=1 and timeout_err=1, and leave txn_cnt unchanged.
REQ-020 If done and the timeout condition occur in the same cycle, done SHALL win: txn_cnt increments and timeout_err is not set.
REQ-021 ACK_HI SHALL hold ack_out=1 until req_s==0, then go to IDLE with ack_out=0 on the next cycle.
REQ-022 done asserted in IDLE or ACK_HI SHALL be ignored, with no state, counter or flag change.
REQ-023 If req_s falls during WAIT_DONE (protocol violation), the FSM SHALL still wait for done or timeout, then drive ack_out high for exactly one cycle before returning to IDLE.
REQ-024 After ACK_HI exits, the FSM SHALL spend at least one cycle in IDLE before accepting a new req_s.
REQ-025 busy SHALL be a registered decode of state!=IDLE, so it rises in the req_pulse cycle and falls in the same cycle ack_out falls.
REQ-026 clr_err==1 SHALL clear timeout_err on the next cycle, and a simultaneous set and clr_err SHALL leave timeout_err at 1.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 When rst is sampled high, the FSM SHALL go to IDLE and the synchronizer chain, timer, req_pulse, ack_out, busy, timeout_err and txn_cnt SHALL all become 0 on that edge.
REQ-029 Reset in WAIT_DONE or ACK_HI SHALL abort the transaction, with ack_out low after the reset edge and no txn_cnt change.
REQ-030 If req_in is still high after rst is released, a new transaction SHALL start, with req_pulse SYNC_STEP+1 cycles after release.

Verification
REQ-031 Nominal case (SYNC_STEP=2): req_in rises at cycle 0 and done pulses at cycle 5 -> req_pulse high at cycle 3 only, ack_out rises at cycle 6, txn_cnt=1; req_in falls at cycle 10 -> ack_out falls at cycle 13, and busy tracks cycles 3..12.
REQ-032 Timeout case (TIMEOUT_CYC=4): req_in held high and done never asserted -> ack_out rises 4 cycles after req_pulse, timeout_err=1, txn_cnt=0; clr_err pulse -> timeout_err=0 one cycle later.
REQ-033 Simultaneous and stray events: done coincides with the timeout cycle -> timeout_err stays 0 and txn_cnt increments; done strobes in IDLE and ACK_HI -> no change.
REQ-034 Counter wrap and back-to-back: 256 back-to-back four-phase transactions -> txn_cnt reads 0 at the end, with exactly 256 req_pulse strobes and at least one IDLE cycle between each pair.
REQ-035 Reset mid-operation: rst during WAIT_DONE with req_in still high -> all outputs 0 after the reset edge; after release, req_pulse is high again 3 cycles later (SYNC_STEP=2).
REQ-036 Protocol violation: req_in drops before done -> ack_out high for exactly 1 cycle after done, then IDLE.
